// File: rtl/div_clock_meter_if.sv
// Result/handshake bundle for div_clock_meter. The master (consumer) drives start,
// the expected counts and meas_ready; the slave (meter) drives the result.
interface div_clock_meter_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] exp_high;
  logic [CNT_W-1:0] exp_low;
  logic             meas_ready;
  logic             meas_valid;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] low_cnt;
  logic [CNT_W:0]   period_cnt;
  logic             meas_ovf;
  logic             meas_err;
  logic             busy;

  modport master (
    output start, exp_high, exp_low, meas_ready,
    input  meas_valid, high_cnt, low_cnt, period_cnt, meas_ovf, meas_err, busy
  );

  modport slave (
    input  start, exp_high, exp_low, meas_ready,
    output meas_valid, high_cnt, low_cnt, period_cnt, meas_ovf, meas_err, busy
  );
endinterface

// File: rtl/div_clock_meter.sv
// Measures high time, low time and period of a divided clock in clk_in cycles.
// Optional expected-count checker: define DIV_CLOCK_METER_CHECK_EN.
//
// state   | meaning
// IDLE    | waiting for start
// ARM     | waiting for a rising edge of sig_in
// MEAS_HI | counting high cycles
// MEAS_LO | counting low cycles
// DONE    | result held on meas_valid until meas_ready
module div_clock_meter #(
  parameter int CNT_W = 16
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic            sig_in,
  div_clock_meter_if.slave mif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    MEAS_HI = 3'd2,
    MEAS_LO = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] ACC_MAX = '1;
  localparam logic [CNT_W-1:0] ACC_ONE = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic             sig_d;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] hi_acc;
  logic [CNT_W-1:0] hi_nxt;
  logic [CNT_W-1:0] lo_acc;
  logic [CNT_W-1:0] lo_nxt;
  logic             capture;
  logic             ovf_nxt;
  logic             err_calc;

  logic             valid_q;
  logic             busy_q;
  logic [CNT_W-1:0] high_q;
  logic [CNT_W-1:0] low_q;
  logic [CNT_W:0]   period_q;
  logic             ovf_q;
  logic             err_q;

  assign rise = sig_in & ~sig_d;
  assign fall = ~sig_in & sig_d;

  always_comb begin
    state_nxt = state;
    hi_nxt    = hi_acc;
    lo_nxt    = lo_acc;
    capture   = 1'b0;
    ovf_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (mif.start) state_nxt = ARM;
      end
      ARM: begin
        // lo_acc is cleared so a high-phase saturation reports a zero low count
        if (rise) begin
          hi_nxt    = ACC_ONE;
          lo_nxt    = '0;
          state_nxt = MEAS_HI;
        end
      end
      MEAS_HI: begin
        if (fall) begin
          lo_nxt    = ACC_ONE;
          state_nxt = MEAS_LO;
        end else if (hi_acc == ACC_MAX) begin
          ovf_nxt   = 1'b1;
          capture   = 1'b1;
          state_nxt = DONE;
        end else begin
          hi_nxt = hi_acc + ACC_ONE;
        end
      end
      MEAS_LO: begin
        if (rise) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else if (lo_acc == ACC_MAX) begin
          ovf_nxt   = 1'b1;
          capture   = 1'b1;
          state_nxt = DONE;
        end else begin
          lo_nxt = lo_acc + ACC_ONE;
        end
      end
      DONE: begin
        if (mif.meas_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef DIV_CLOCK_METER_CHECK_EN
  assign err_calc = (hi_acc != mif.exp_high) | (lo_acc != mif.exp_low) | ovf_nxt;
`else
  logic unused_exp;
  assign unused_exp = ^{mif.exp_high, mif.exp_low};
  assign err_calc   = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state    <= IDLE;
      sig_d    <= 1'b0;
      hi_acc   <= '0;
      lo_acc   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      high_q   <= '0;
      low_q    <= '0;
      period_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      sig_d   <= sig_in;
      hi_acc  <= hi_nxt;
      lo_acc  <= lo_nxt;
      valid_q <= (state_nxt == DONE);
      busy_q  <= (state_nxt != IDLE);
      if (capture) begin
        high_q   <= hi_acc;
        low_q    <= lo_acc;
        period_q <= {1'b0, hi_acc} + {1'b0, lo_acc};
        ovf_q    <= ovf_nxt;
        err_q    <= err_calc;
      end
    end
  end

  assign mif.meas_valid = valid_q;
  assign mif.busy       = busy_q;
  assign mif.high_cnt   = high_q;
  assign mif.low_cnt    = low_q;
  assign mif.period_cnt = period_q;
  assign mif.meas_ovf   = ovf_q;
  assign mif.meas_err   = err_q;

endmodule

// File: tb/tb_div_clock_meter.sv
// Scoreboard bench for div_clock_meter: a 16-bit instance for ratio/duty/handshake
// cases and a 4-bit instance for saturation.
module tb_div_clock_meter;

  logic clk_in = 1'b0;
  logic rst;
  logic sig_a;
  logic sig_b;

  always #5 clk_in = ~clk_in;

  div_clock_meter_if #(.CNT_W(16)) ma ();
  div_clock_meter_if #(.CNT_W(4))  mb ();

  div_clock_meter #(.CNT_W(16)) dut_a (.clk_in(clk_in), .rst(rst), .sig_in(sig_a), .mif(ma.slave));
  div_clock_meter #(.CNT_W(4))  dut_b (.clk_in(clk_in), .rst(rst), .sig_in(sig_b), .mif(mb.slave));

`ifdef DIV_CLOCK_METER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    int hi;
    int lo;
    int per;
    bit ovf;
    bit err;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;
  int   checks = 0;
  int   errors = 0;

  int   hi_len = 14;
  int   lo_len = 14;
  int   ph     = 0;
  bit   gen_on = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Divided-clock generator for instance A: hi_len cycles high, lo_len cycles low.
  initial begin
    forever begin
      @(negedge clk_in);
      if (gen_on) begin
        sig_a = (ph < hi_len);
        ph    = (ph + 1 >= hi_len + lo_len) ? 0 : ph + 1;
      end else begin
        ph = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake.
  initial begin
    forever begin
      @(negedge clk_in);
      if (ma.meas_valid && ma.meas_ready) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_a: got a result expected none");
        end else begin
          ea = qa.pop_front();
          check("a_high",   ma.high_cnt,   ea.hi);
          check("a_low",    ma.low_cnt,    ea.lo);
          check("a_period", ma.period_cnt, ea.per);
          check("a_ovf",    ma.meas_ovf,   ea.ovf);
          check("a_err",    ma.meas_err,   ea.err);
        end
      end
      if (mb.meas_valid && mb.meas_ready) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_b: got a result expected none");
        end else begin
          eb = qb.pop_front();
          check("b_high",   mb.high_cnt,   eb.hi);
          check("b_low",    mb.low_cnt,    eb.lo);
          check("b_period", mb.period_cnt, eb.per);
          check("b_ovf",    mb.meas_ovf,   eb.ovf);
          check("b_err",    mb.meas_err,   eb.err);
        end
      end
    end
  end

  task automatic wait_idle_a(int budget);
    int n = 0;
    while (ma.busy && n < budget) begin
      tick(1);
      n++;
    end
    if (ma.busy) begin
      checks++; errors++;
      $display("FAIL timeout_a: got busy=1 expected busy=0 within %0d cycles", budget);
    end
  endtask

  task automatic run_a(int hl, int ll, logic [15:0] eh, logic [15:0] el, exp_t e);
    gen_on = 1'b0;
    sig_a  = 1'b0;
    tick(2);
    hi_len      = hl;
    lo_len      = ll;
    ma.exp_high = eh;
    ma.exp_low  = el;
    gen_on      = 1'b1;
    tick(3);
    qa.push_back(e);
    ma.start = 1'b1;
    tick(1);
    ma.start = 1'b0;
    wait_idle_a(50 + 4 * (hl + ll));
  endtask

  task automatic check_a_zero(string tag);
    check({tag, "_valid"},  ma.meas_valid, 0);
    check({tag, "_busy"},   ma.busy,       0);
    check({tag, "_high"},   ma.high_cnt,   0);
    check({tag, "_low"},    ma.low_cnt,    0);
    check({tag, "_period"}, ma.period_cnt, 0);
    check({tag, "_ovf"},    ma.meas_ovf,   0);
    check({tag, "_err"},    ma.meas_err,   0);
  endtask

  initial begin
    int n;
    rst           = 1'b0;
    sig_a         = 1'b0;
    sig_b         = 1'b0;
    ma.start      = 1'b0;
    ma.exp_high   = '0;
    ma.exp_low    = '0;
    ma.meas_ready = 1'b1;
    mb.start      = 1'b0;
    mb.exp_high   = '0;
    mb.exp_low    = '0;
    mb.meas_ready = 1'b1;
    tick(2);
    check_a_zero("reset");
    check("reset_b_valid", mb.meas_valid, 0);
    rst = 1'b1;
    tick(2);

    // Divide-by-28, checker expectations matching and mismatching
    run_a(14, 14, 16'd14, 16'd14, '{hi: 14, lo: 14, per: 28, ovf: 1'b0, err: 1'b0});
    run_a(14, 14, 16'd14, 16'd13, '{hi: 14, lo: 14, per: 28, ovf: 1'b0, err: CHK});
    // 33% duty and divide-by-2
    run_a(1, 2, 16'd0, 16'd0, '{hi: 1, lo: 2, per: 3, ovf: 1'b0, err: CHK});
    run_a(1, 1, 16'd1, 16'd1, '{hi: 1, lo: 1, per: 2, ovf: 1'b0, err: 1'b0});

    // 4-bit saturation: sig_b rises once and stays high
    qb.push_back('{hi: 15, lo: 0, per: 15, ovf: 1'b1, err: CHK});
    mb.start = 1'b1;
    tick(1);
    mb.start = 1'b0;
    tick(1);
    sig_b = 1'b1;
    n = 0;
    while (mb.busy && n < 100) begin
      tick(1);
      n++;
    end
    if (mb.busy) begin
      checks++; errors++;
      $display("FAIL timeout_b: got busy=1 expected busy=0 within 100 cycles");
    end

    // Result held while meas_ready is low; start during the wait is ignored
    gen_on = 1'b0;
    sig_a  = 1'b0;
    tick(2);
    hi_len        = 1;
    lo_len        = 2;
    ma.exp_high   = 16'd1;
    ma.exp_low    = 16'd2;
    ma.meas_ready = 1'b0;
    gen_on        = 1'b1;
    tick(3);
    qa.push_back('{hi: 1, lo: 2, per: 3, ovf: 1'b0, err: 1'b0});
    ma.start = 1'b1;
    tick(1);
    ma.start = 1'b0;
    n = 0;
    while (!ma.meas_valid && n < 100) begin
      tick(1);
      n++;
    end
    check("hold_valid_rises", ma.meas_valid, 1);
    for (int i = 0; i < 20; i++) begin
      ma.start = (i == 5);
      tick(1);
      check("hold_valid",  ma.meas_valid, 1);
      check("hold_result", {ma.high_cnt, ma.low_cnt, ma.period_cnt}, {16'd1, 16'd2, 17'd3});
    end
    ma.start = 1'b0;
    @(posedge clk_in);
    #1 ma.meas_ready = 1'b1;
    tick(1);
    tick(1);
    check("post_hs_valid", ma.meas_valid, 0);
    check("post_hs_busy",  ma.busy,       0);
    check("post_hs_high",  ma.high_cnt,   1);
    tick(3);
    check("start_not_queued", ma.busy, 0);

    // Reset while in MEAS_LO aborts the measurement
    gen_on      = 1'b0;
    sig_a       = 1'b0;
    ma.exp_high = 16'd3;
    ma.exp_low  = 16'd5;
    tick(2);
    ma.start = 1'b1;
    tick(1);
    ma.start = 1'b0;
    sig_a    = 1'b1;
    tick(3);
    sig_a = 1'b0;
    tick(2);
    check("mid_busy", ma.busy, 1);
    rst = 1'b0;
    tick(1);
    check_a_zero("midrst");
    rst = 1'b1;
    tick(2);
    run_a(3, 5, 16'd3, 16'd5, '{hi: 3, lo: 5, per: 8, ovf: 1'b0, err: 1'b0});

    tick(5);
    check("scoreboard_a_drained", qa.size(), 0);
    check("scoreboard_b_drained", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_clock_meter.md
# div_clock_meter

Measures the high time, low time and period of one divided clock produced by the clock generator, counting whole cycles of `clk_in`. The input signal must be synchronous to `clk_in`. A single measurement starts on a `start` pulse and is held on a valid/ready result port until consumed. With the optional checker compiled in, the block also compares the result against expected counts, so the bench or board logic can confirm a divider's ratio and duty cycle.

## Interface
- `CNT_W`, default 16: width of the high and low counters. Period is `CNT_W+1` bits.
- `clk_in`  in  1: the single clock. All logic is on its posedge.
- `rst`  in  1: synchronous, active-low reset.
- `sig_in`  in  1: divided clock under test, synchronous to `clk_in`.
- `start`  in  1: one-cycle request to begin a measurement. Honoured only in IDLE.
- `exp_high`  in  CNT_W: expected high count. Used only with the checker.
- `exp_low`  in  CNT_W: expected low count. Used only with the checker.
- `meas_ready`  in  1: consumer accepts the result.
- `meas_valid`  out  1: a result is available.
- `high_cnt`  out  CNT_W: cycles `sig_in` was 1.
- `low_cnt`  out  CNT_W: cycles `sig_in` was 0.
- `period_cnt`  out  CNT_W+1: `high_cnt + low_cnt`, zero-extended, no truncation.
- `meas_ovf`  out  1: a counter saturated during the measurement.
- `meas_err`  out  1: mismatch against the expected counts.
- `busy`  out  1: state is not IDLE.

## Operation
- Edge detect:
  - `sig_d` is `sig_in` delayed one cycle.
  - `rise = sig_in & ~sig_d`.
  - `fall = ~sig_in & sig_d`.
- States: IDLE, ARM, MEAS_HI, MEAS_LO, DONE.
- IDLE: when `start` is 1, go to ARM. Otherwise stay.
- ARM: wait for `rise`. On `rise`, set `hi_acc <= 1` and go to MEAS_HI. There is no timeout.
- MEAS_HI:
  - On `fall`: set `lo_acc <= 1` and go to MEAS_LO.
  - Otherwise, if `hi_acc` is all ones: set the ovf flag and go to DONE.
  - Otherwise: `hi_acc <= hi_acc + 1`.
- MEAS_LO:
  - On `rise`: go to DONE. The terminating rise is not counted.
  - Otherwise, if `lo_acc` is all ones: set the ovf flag and go to DONE.
  - Otherwise: `lo_acc <= lo_acc + 1`.
- On every transition into DONE, register `high_cnt`, `low_cnt`, `period_cnt`, `meas_ovf` and `meas_err` from the accumulators.
- DONE:
  - `meas_valid = 1`. All result outputs are stable.
  - When `meas_ready` is 1, go to IDLE.
  - `meas_ready` is ignored in every other state.
- `start` outside IDLE is ignored and is not queued.
- Result outputs keep their last value after the handshake until the next capture.
- `sig_d` updates in every state, so an edge already in progress when ARM is entered is not seen twice.

## Timing
- Reset values (when `rst` is 0 at a posedge):
  - State is IDLE.
  - `sig_d`, `hi_acc` and `lo_acc` are 0.
  - All outputs are 0, including `meas_valid`, all counts, `meas_ovf`, `meas_err` and `busy`.
- Reset wins over every other input. Reset mid-measurement aborts it and no result is produced.
- `meas_valid` rises on the cycle after the terminating `rise` is sampled (or after the saturating cycle). All outputs are registered.
- Handshake: the transfer happens on the cycle where `meas_valid` and `meas_ready` are both 1. `meas_valid` is 0 on the next cycle.
- A `start` on the cycle of the handshake is ignored, because the state is still DONE.
- From `start` to `meas_valid`, the minimum is 1 + (wait for rise) + high + low + 1 cycles.
- Saturation: the counters stop at 2^CNT_W − 1. `period_cnt` still equals the sum of the reported counts.

## Configuration
- Macro `DIV_CLOCK_METER_CHECK_EN`:
  - Defined: at capture, `meas_err = (hi_acc != exp_high) | (lo_acc != exp_low) | ovf`. It is registered with the other results.
  - Not defined: `meas_err` is tied 0. `exp_high` and `exp_low` are unused and no comparator logic exists.

## Test plan
- `sig_in` toggling every 14 cycles (the divide-by-28 output), `start`, `meas_ready` held 1 -> `high_cnt=14`, `low_cnt=14`, `period_cnt=28`, `meas_ovf=0`.
- `sig_in` high 1 cycle, low 2 cycles (33% duty) -> 1 / 2 / 3. Divide-by-2 input -> 1 / 1 / 2.
- `CNT_W=4`, `sig_in` held 1 after one rise -> `high_cnt=15`, `low_cnt=0`, `meas_ovf=1`. Check `meas_err=1` when the checker is compiled in.
- Checker compiled in, divide-by-28 input:
  - `exp_high=14`, `exp_low=14` -> `meas_err=0`.
  - `exp_low=13` -> `meas_err=1`.
  - Macro undefined -> `meas_err=0` in both cases.
- `meas_ready` held 0 for 20 cycles after `meas_valid` -> outputs held stable. A `start` pulse during this wait is ignored. Raising `meas_ready` leaves `meas_valid=0` on the next cycle and `busy=0`.
- `rst` driven 0 for one cycle in MEAS_LO -> all outputs 0 next cycle. A new `start` gives a correct fresh measurement.
